// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master: FSM state encoding, parameter
// defaults and the slave-index width carved out of req_addr[13:12].
// No ports; imported by the interface, the decoder and the top level.
package apb_pkg;

  localparam int          NUM_SLV_DEF = 4;
  localparam logic [15:0] BASE_DEF    = 16'h1000;
  localparam int          TIMEOUT_DEF = 16;

  // Slave index comes from req_addr[13:12].
  localparam int          IDX_W       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Bundle of the request/response handshake and the APB bus signals.
//   req_*  : request side (valid/ready handshake, address, direction, data)
//   rsp_*  : one-cycle completion pulse with read data and error flag
//   P*     : APB master outputs and per-slave PRDATA/PREADY inputs
// modport master : seen by apb_master
// modport slave  : the opposite direction, for the requester/slave side
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int NUM_SLV = NUM_SLV_DEF
);

  logic                      req_valid;
  logic                      req_ready;
  logic [31:0]               req_addr;
  logic                      req_write;
  logic [31:0]               req_wdata;

  logic                      rsp_valid;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;

  logic [31:0]               PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PENABLE;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV-1:0][31:0]  PRDATA;
  logic [NUM_SLV-1:0]        PREADY;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWDATA, PWRITE, PENABLE, PSEL
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PADDR, PWDATA, PWRITE, PENABLE, PSEL
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational address decode for the APB master.
//   addr_hi  : req_addr[31:16], must equal BASE
//   addr_slv : req_addr[13:12], slave index
//   mapped   : address hits BASE and an existing slave
//   idx      : slave index (meaningful only when mapped)
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV = NUM_SLV_DEF,
  parameter logic [15:0] BASE    = BASE_DEF
) (
  input  logic [15:0]      addr_hi,
  input  logic [IDX_W-1:0] addr_slv,
  output logic             mapped,
  output logic [IDX_W-1:0] idx
);

  assign idx    = addr_slv;
  assign mapped = (addr_hi == BASE) &&
                  ({30'd0, addr_slv} < 32'(NUM_SLV));

endmodule

// File: rtl/apb_master.sv
// APB master: accepts one request at a time over a valid/ready handshake,
// runs the IDLE -> SETUP -> ACCESS sequence on the APB bus and returns a
// one-cycle response pulse.  Unmapped requests and slaves that stay
// not-ready for TIMEOUT ACCESS cycles are answered with rsp_err=1.
//   PCLK   : clock, rising edge
//   PRESET : synchronous active-low reset
//   bus    : apb_master_if.master (request, response and APB signals)
// All bus and response outputs are registered; req_ready is a decode of the
// state register.
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLV = NUM_SLV_DEF,
  parameter logic [15:0] BASE    = BASE_DEF,
  parameter int          TIMEOUT = TIMEOUT_DEF
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e           state_r, state_n;
  logic [NUM_SLV-1:0]   psel_r, psel_n;
  logic                 penable_r, penable_n;
  logic [31:0]          paddr_r, paddr_n;
  logic [31:0]          pwdata_r, pwdata_n;
  logic                 pwrite_r, pwrite_n;
  logic                 rsp_valid_r, rsp_valid_n;
  logic                 rsp_err_r, rsp_err_n;
  logic [31:0]          rsp_rdata_r, rsp_rdata_n;
  logic [IDX_W-1:0]     idx_r, idx_n;
  logic [CNT_W-1:0]     wait_r, wait_n;

  logic                 dec_mapped_s;
  logic [IDX_W-1:0]     dec_idx_s;
  logic                 pready_sel_s;
  logic [31:0]          prdata_sel_s;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .BASE    (BASE)
  ) u_dec (
    .addr_hi  (bus.req_addr[31:16]),
    .addr_slv (bus.req_addr[13:12]),
    .mapped   (dec_mapped_s),
    .idx      (dec_idx_s)
  );

  // Select the active slave's PREADY/PRDATA using the latched index.
  always_comb begin
    pready_sel_s = 1'b0;
    prdata_sel_s = 32'd0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_r == IDX_W'(i)) begin
        pready_sel_s = bus.PREADY[i];
        prdata_sel_s = bus.PRDATA[i];
      end else begin
        pready_sel_s = pready_sel_s;
        prdata_sel_s = prdata_sel_s;
      end
    end
  end

  // Next-state and next-output logic; bus fields hold unless changed.
  always_comb begin
    state_n     = state_r;
    psel_n      = psel_r;
    penable_n   = penable_r;
    paddr_n     = paddr_r;
    pwdata_n    = pwdata_r;
    pwrite_n    = pwrite_r;
    idx_n       = idx_r;
    wait_n      = wait_r;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = 32'd0;

    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          if (dec_mapped_s) begin
            state_n   = SETUP;
            paddr_n   = bus.req_addr;
            pwdata_n  = bus.req_wdata;
            pwrite_n  = bus.req_write;
            idx_n     = dec_idx_s;
            wait_n    = '0;
            penable_n = 1'b0;
            for (int i = 0; i < NUM_SLV; i++) begin
              psel_n[i] = (dec_idx_s == IDX_W'(i));
            end
          end else begin
            // Unmapped: answer immediately with an error, bus untouched.
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end

      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end

      ACCESS: begin
        // PREADY wins over a timeout reached on the same edge.
        if (pready_sel_s) begin
          state_n     = IDLE;
          psel_n      = '0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = pwrite_r ? 32'd0 : prdata_sel_s;
        end else if (wait_r == CNT_W'(TIMEOUT - 1)) begin
          state_n     = IDLE;
          psel_n      = '0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
        end else begin
          wait_n = wait_r + CNT_W'(1);
        end
      end

      default: begin
        state_n   = IDLE;
        psel_n    = '0;
        penable_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_r     <= IDLE;
      psel_r      <= '0;
      penable_r   <= 1'b0;
      paddr_r     <= 32'd0;
      pwdata_r    <= 32'd0;
      pwrite_r    <= 1'b0;
      idx_r       <= '0;
      wait_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else begin
      state_r     <= state_n;
      psel_r      <= psel_n;
      penable_r   <= penable_n;
      paddr_r     <= paddr_n;
      pwdata_r    <= pwdata_n;
      pwrite_r    <= pwrite_n;
      idx_r       <= idx_n;
      wait_r      <= wait_n;
      rsp_valid_r <= rsp_valid_n;
      rsp_err_r   <= rsp_err_n;
      rsp_rdata_r <= rsp_rdata_n;
    end
  end

  assign bus.req_ready = (state_r == IDLE);
  assign bus.PSEL      = psel_r;
  assign bus.PENABLE   = penable_r;
  assign bus.PADDR     = paddr_r;
  assign bus.PWDATA    = pwdata_r;
  assign bus.PWRITE    = pwrite_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master with default parameters
// (4 slaves, BASE 16'h1000, TIMEOUT 16).  Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_apb_master;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  apb_master_if #(.NUM_SLV(4)) bus ();

  apb_master dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h1000_0000;
    bus.req_write  = 1'b0;
    bus.req_wdata  = 32'd0;
    bus.PREADY     = 4'b0000;
    bus.PRDATA     = '0;

    // Reset, with a request pending that must not be taken.
    bus.req_valid = 1'b1;
    tick();
    tick();
    chk("rst_ready",   32'(bus.req_ready), 32'd1);
    chk("rst_psel",    32'(bus.PSEL),      32'd0);
    chk("rst_penable", 32'(bus.PENABLE),   32'd0);
    chk("rst_rsp",     32'(bus.rsp_valid), 32'd0);
    chk("rst_paddr",   bus.PADDR,          32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Write to slave 0 with PREADY held high: minimum latency.
    bus.PREADY    = 4'b1111;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_0004;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'hDEAD_BEEF;
    tick();                                   // accept edge
    bus.req_valid = 1'b0;
    chk("w_setup_psel",    32'(bus.PSEL),      32'h1);
    chk("w_setup_penable", 32'(bus.PENABLE),   32'd0);
    chk("w_setup_paddr",   bus.PADDR,          32'h1000_0004);
    chk("w_setup_pwdata",  bus.PWDATA,         32'hDEAD_BEEF);
    chk("w_setup_pwrite",  32'(bus.PWRITE),    32'd1);
    chk("w_setup_ready",   32'(bus.req_ready), 32'd0);
    tick();
    chk("w_access_penable", 32'(bus.PENABLE),  32'd1);
    chk("w_access_psel",    32'(bus.PSEL),     32'h1);
    chk("w_access_rsp",     32'(bus.rsp_valid), 32'd0);
    tick();
    chk("w_done_rsp",     32'(bus.rsp_valid), 32'd1);
    chk("w_done_err",     32'(bus.rsp_err),   32'd0);
    chk("w_done_rdata",   bus.rsp_rdata,      32'd0);
    chk("w_done_psel",    32'(bus.PSEL),      32'd0);
    chk("w_done_penable", 32'(bus.PENABLE),   32'd0);
    chk("w_done_ready",   32'(bus.req_ready), 32'd1);
    chk("w_idle_paddr",   bus.PADDR,          32'h1000_0004);
    tick();
    chk("w_pulse_len",    32'(bus.rsp_valid), 32'd0);

    // Read slave 2 with three wait states; other slaves ready (ignored).
    bus.PREADY    = 4'b1011;
    bus.PRDATA[0] = 32'hAAAA_AAAA;
    bus.PRDATA[2] = 32'h1234_5678;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_2008;
    bus.req_write = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk("r_setup_psel",    32'(bus.PSEL),    32'h4);
    chk("r_setup_penable", 32'(bus.PENABLE), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.PREADY = 4'b1111;
      chk("r_acc_penable", 32'(bus.PENABLE),   32'd1);
      chk("r_acc_psel",    32'(bus.PSEL),      32'h4);
      chk("r_acc_paddr",   bus.PADDR,          32'h1000_2008);
      chk("r_acc_pwrite",  32'(bus.PWRITE),    32'd0);
      chk("r_acc_rsp",     32'(bus.rsp_valid), 32'd0);
      tick();
    end
    chk("r_done_rsp",   32'(bus.rsp_valid), 32'd1);
    chk("r_done_err",   32'(bus.rsp_err),   32'd0);
    chk("r_done_rdata", bus.rsp_rdata,      32'h1234_5678);
    chk("r_done_psel",  32'(bus.PSEL),      32'd0);
    tick();

    // Read slave 3, never ready: abort after 16 ACCESS cycles.
    bus.PREADY    = 4'b0111;
    bus.PRDATA[3] = 32'h5555_5555;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_3000;
    tick();
    bus.req_valid = 1'b0;
    chk("to_setup_psel", 32'(bus.PSEL), 32'h8);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_acc_penable", 32'(bus.PENABLE),   32'd1);
      chk("to_acc_rsp",     32'(bus.rsp_valid), 32'd0);
      tick();
    end
    chk("to_rsp",     32'(bus.rsp_valid), 32'd1);
    chk("to_err",     32'(bus.rsp_err),   32'd1);
    chk("to_rdata",   bus.rsp_rdata,      32'd0);
    chk("to_psel",    32'(bus.PSEL),      32'd0);
    chk("to_penable", 32'(bus.PENABLE),   32'd0);
    tick();

    // PREADY on the 16th ACCESS cycle beats the timeout.
    bus.PREADY    = 4'b0000;
    bus.PRDATA[3] = 32'hCAFE_F00D;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_3004;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) bus.PREADY = 4'b1000;
      chk("pri_acc_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    chk("pri_rsp",   32'(bus.rsp_valid), 32'd1);
    chk("pri_err",   32'(bus.rsp_err),   32'd0);
    chk("pri_rdata", bus.rsp_rdata,      32'hCAFE_F00D);
    bus.PREADY = 4'b0000;
    tick();

    // Unmapped request, then a back-to-back mapped write.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h2000_0000;
    bus.req_write = 1'b0;
    tick();
    chk("um_rsp",   32'(bus.rsp_valid), 32'd1);
    chk("um_err",   32'(bus.rsp_err),   32'd1);
    chk("um_rdata", bus.rsp_rdata,      32'd0);
    chk("um_psel",  32'(bus.PSEL),      32'd0);
    chk("um_ready", 32'(bus.req_ready), 32'd1);
    bus.req_addr  = 32'h1000_1010;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h0BAD_F00D;
    bus.PREADY    = 4'b0010;
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_psel",   32'(bus.PSEL),      32'h2);
    chk("b2b_paddr",  bus.PADDR,          32'h1000_1010);
    chk("b2b_pwdata", bus.PWDATA,         32'h0BAD_F00D);
    chk("b2b_rsp",    32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    chk("b2b_done_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_done_err", 32'(bus.rsp_err),   32'd0);
    tick();

    // Upper address half off BASE is unmapped too.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1001_0000;
    tick();
    bus.req_valid = 1'b0;
    chk("um2_err",  32'(bus.rsp_err), 32'd1);
    chk("um2_psel", 32'(bus.PSEL),    32'd0);
    tick();

    // Reset during ACCESS abandons the transfer.
    bus.PREADY    = 4'b0000;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_0008;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h1111_2222;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rA_penable", 32'(bus.PENABLE), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rA_psel",    32'(bus.PSEL),      32'd0);
    chk("rA_penable0", 32'(bus.PENABLE),  32'd0);
    chk("rA_rsp",     32'(bus.rsp_valid), 32'd0);
    chk("rA_ready",   32'(bus.req_ready), 32'd1);
    chk("rA_paddr",   bus.PADDR,          32'd0);
    tick();
    chk("rA_rsp2",    32'(bus.rsp_valid), 32'd0);

    // Follow-up write completes normally.
    bus.PREADY    = 4'b0001;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("rW_psel", 32'(bus.PSEL), 32'h1);
    tick();
    tick();
    chk("rW_rsp",   32'(bus.rsp_valid), 32'd1);
    chk("rW_err",   32'(bus.rsp_err),   32'd0);
    chk("rW_rdata", bus.rsp_rdata,      32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
